// File: rtl/load_scheduler_pkg.sv
// Shared types and memory geometry for the host load/launch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package load_scheduler_pkg;

    // Command target encoding carried on cmd_target
    typedef enum logic [1:0] {
        TGT_INST = 2'd0,
        TGT_W    = 2'd1,
        TGT_XY   = 2'd2,
        TGT_RUN  = 2'd3
    } LoadTarget;

    // Array and memory geometry (depths are powers of two so address wrap is a plain truncation)
    localparam int NU_COUNT       = 4;
    localparam int INST_MEM_SIZE  = 48;
    localparam int INST_MEM_DEPTH = 64;
    localparam int W_MEM_DEPTH    = 32;
    localparam int XY_MEM_DEPTH   = 16;

    localparam int INST_ADDR_W = $clog2(INST_MEM_DEPTH);
    localparam int W_ADDR_W    = $clog2(W_MEM_DEPTH);
    localparam int XY_ADDR_W   = $clog2(XY_MEM_DEPTH);
    localparam int NU_IDX_W    = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1;

    // Host beats needed to build one instruction word of the given host word width
    function automatic int inst_beats(input int dw);
        return (INST_MEM_SIZE + dw - 1) / dw;
    endfunction

    localparam int HOST_WORD_W = 16;
    localparam int INST_BEATS  = inst_beats(HOST_WORD_W);

endpackage

// File: rtl/load_scheduler_inst_word_packer.sv
// Packs host beats little-endian (beat 0 in LSBs) into one instruction word.
// Latency: word + strobe registered, valid the cycle after the final beat is accepted.
// Backpressure: none; accepts one beat per cycle whenever beat_vld is high.
module inst_word_packer #(
    parameter int DW     = 16,
    parameter int BEATS  = 3,
    parameter int WORD_W = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              beat_vld,
    input  logic [DW-1:0]     beat_dat,
    output logic              beat_last,
    output logic              word_vld,
    output logic [WORD_W-1:0] word_dat
);

    localparam int PACK_W = BEATS * DW;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [PACK_W-1:0] pack_q;
    logic [PACK_W-1:0] full_c;
    logic [CNT_W-1:0]  cnt_q;

    assign beat_last = (cnt_q == CNT_W'(BEATS - 1));

    // Full word as it will look once the incoming final beat lands in the top slot
    always_comb begin
        full_c = pack_q;
        full_c[(BEATS-1)*DW +: DW] = beat_dat;
    end

    // Beat shift/count register; a partial word is dropped on clear or reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pack_q   <= '0;
            cnt_q    <= '0;
            word_vld <= 1'b0;
            word_dat <= '0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                pack_q <= '0;
                cnt_q  <= '0;
            end else if (beat_vld) begin
                if (beat_last) begin
                    word_vld <= 1'b1;
                    word_dat <= full_c[WORD_W-1:0];
                    pack_q   <= '0;
                    cnt_q    <= '0;
                end else begin
                    pack_q[cnt_q*DW +: DW] <= beat_dat;
                    cnt_q                  <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/load_scheduler.sv
// Host load/launch sequencer: scatters host words into INST/W/XY memories, then launches and tracks a RUN.
// Latency: memory writes registered, 1 cycle after beat accept; run high the cycle after a RUN command.
// Backpressure: data_ready only in LOAD (state-only); cmd_ready only in IDLE. Optional LOAD_CHECKSUM_EN adds checksum output.
module load_scheduler
    import load_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_target,
    input  logic [LEN_WIDTH-1:0]     cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_length,
    input  logic                     data_valid,
    output logic                     data_ready,
    input  logic [DATA_WIDTH-1:0]    data,
    input  logic                     ctrl_idle,
    output logic                     run,
    output logic                     busy,
    output logic                     done,
    output logic                     inst_write_enable,
    output logic [INST_ADDR_W-1:0]   inst_write_addr,
    output logic [INST_MEM_SIZE-1:0] inst_write_data,
    output logic [NU_COUNT-1:0]      w_write_enable,
    output logic [W_ADDR_W-1:0]      w_write_addr,
    output logic [DATA_WIDTH-1:0]    w_write_data,
    output logic                     xy_write_enable,
    output logic [XY_ADDR_W-1:0]     xy_write_addr,
    output logic [DATA_WIDTH-1:0]    xy_write_data
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    checksum
`endif
);

    localparam int BEATS = inst_beats(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GATE       = 3'd1,
        LOAD       = 3'd2,
        RUN_ASSERT = 3'd3,
        RUN_WAIT   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    LoadTarget              tgt_q;
    logic [LEN_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [NU_IDX_W-1:0]    nu_q;
    logic [LEN_WIDTH-1:0]   row_q;
    logic [LEN_WIDTH-1:0]   inst_row_q;

    logic cmd_acc;
    logic beat_acc;
    logic last_beat;
    logic pk_last;

    // cmd_ready is held low while reset is asserted even though the state is IDLE
    assign cmd_ready  = (state_q == IDLE) && reset;
    assign data_ready = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign run        = (state_q == RUN_ASSERT);
    assign done       = (state_q == RUN_WAIT) && ctrl_idle;

    assign cmd_acc   = cmd_valid && cmd_ready;
    assign beat_acc  = data_valid && data_ready;
    assign last_beat = (cnt_q == len_q - LEN_WIDTH'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ctrl_idle is deliberately ignored once LOAD has begun
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    if (LoadTarget'(cmd_target) == TGT_RUN) begin
                        state_d = RUN_ASSERT;
                    end else if (cmd_length != '0) begin
                        state_d = GATE;
                    end
                end
            end
            GATE: begin
                if (ctrl_idle) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat_acc && last_beat) begin
                    state_d = IDLE;
                end
            end
            RUN_ASSERT: begin
                if (!ctrl_idle) begin
                    state_d = RUN_WAIT;
                end
            end
            RUN_WAIT: begin
                if (ctrl_idle) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch and word/NU/row counters; NU index and row avoid a divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q      <= TGT_INST;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            nu_q       <= '0;
            row_q      <= '0;
            inst_row_q <= '0;
        end else if (cmd_acc) begin
            tgt_q      <= LoadTarget'(cmd_target);
            addr_q     <= cmd_addr;
            len_q      <= cmd_length;
            cnt_q      <= '0;
            nu_q       <= '0;
            row_q      <= '0;
            inst_row_q <= '0;
        end else if (beat_acc) begin
            cnt_q <= cnt_q + 1'b1;
            if (tgt_q == TGT_W) begin
                if (nu_q == NU_IDX_W'(NU_COUNT - 1)) begin
                    nu_q  <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    nu_q <= nu_q + 1'b1;
                end
            end
            if (tgt_q == TGT_INST && pk_last) begin
                inst_row_q <= inst_row_q + 1'b1;
            end
        end
    end

    // Registered W/XY write ports and INST write address; addresses wrap at memory depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_write_enable  <= '0;
            w_write_addr    <= '0;
            w_write_data    <= '0;
            xy_write_enable <= 1'b0;
            xy_write_addr   <= '0;
            xy_write_data   <= '0;
            inst_write_addr <= '0;
        end else begin
            w_write_enable  <= '0;
            xy_write_enable <= 1'b0;
            if (beat_acc) begin
                case (tgt_q)
                    TGT_W: begin
                        w_write_enable <= NU_COUNT'(1) << nu_q;
                        w_write_addr   <= W_ADDR_W'(addr_q + row_q);
                        w_write_data   <= data;
                    end
                    TGT_XY: begin
                        xy_write_enable <= 1'b1;
                        xy_write_addr   <= XY_ADDR_W'(addr_q + cnt_q);
                        xy_write_data   <= data;
                    end
                    TGT_INST: begin
                        if (pk_last) begin
                            inst_write_addr <= INST_ADDR_W'(addr_q + inst_row_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    inst_word_packer #(
        .DW     (DATA_WIDTH),
        .BEATS  (BEATS),
        .WORD_W (INST_MEM_SIZE)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (cmd_acc),
        .beat_vld  (beat_acc && (tgt_q == TGT_INST)),
        .beat_dat  (data),
        .beat_last (pk_last),
        .word_vld  (inst_write_enable),
        .word_dat  (inst_write_data)
    );

`ifdef LOAD_CHECKSUM_EN
    // Running sum of accepted words, restarted by every load command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (cmd_acc && (LoadTarget'(cmd_target) != TGT_RUN)) begin
            checksum <= '0;
        end else if (beat_acc) begin
            checksum <= checksum + data;
        end
    end
`endif

endmodule

// File: doc/load_scheduler.md
# load_scheduler

Host-side load and launch sequencer for the accelerator. Accepts commands and a word stream from the host link, scatters data into instruction, per-NU weight and XY memories, then hands the array to the layer controller by driving `status.run` and tracking completion. Owns the memory write ports whenever the layer controller is idle.

## Interface
- `DATA_WIDTH`, 16: host data word width; equals weight/XY word width.
- `LEN_WIDTH`, 16: command length/address width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `cmd_target`  in  2  `LoadTarget`: `TGT_INST`=0, `TGT_W`=1, `TGT_XY`=2, `TGT_RUN`=3.
- `cmd_addr`  in  `LEN_WIDTH`  base word address (for RUN: ignored).
- `cmd_length`  in  `LEN_WIDTH`  data words to follow; 0 = no-op.
- `data_valid` / `data_ready`  in / out  1  data handshake.
- `data`  in  `DATA_WIDTH`  payload word.
- `ctrl_idle`  in  1  layer controller is in its RESET state.
- `run`  out  1  drives `status.run`.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at end of a RUN.
- `inst_write_enable`, `inst_write_addr`, `inst_write_data`  out  1, `INST_MEM_DEPTH`, `INST_MEM_SIZE`.
- `w_write_enable`, `w_write_addr`, `w_write_data`  out  `NU_COUNT`, `W_MEM_DEPTH`, `DATA_WIDTH`.
- `xy_write_enable`, `xy_write_addr`, `xy_write_data`  out  1, `XY_MEM_DEPTH`, `DATA_WIDTH`.

## Operation
- States: IDLE, GATE, LOAD, RUN_ASSERT, RUN_WAIT.
- IDLE: `cmd_ready`=1. On accept, latch target/addr/length. Length 0 and non-RUN: stay IDLE. RUN: -> RUN_ASSERT. Else -> GATE.
- GATE: wait for `ctrl_idle`=1, then -> LOAD. Memory ports never written while controller active.
- LOAD: `data_ready`=1. Word counter `i` from 0 to length-1; after last accepted beat -> IDLE.
  - INST: `INST_BEATS` = ceil(`INST_MEM_SIZE`/`DATA_WIDTH`) beats packed little-endian (beat 0 in LSBs) into one word; write at addr + i/`INST_BEATS` on final beat. Length not a multiple of `INST_BEATS`: trailing partial word dropped.
  - W: interleaved; word i -> NU `i % NU_COUNT`, address addr + i/`NU_COUNT`; one-hot `w_write_enable`. NU index and row held as separate counters (no divider).
  - XY: address addr + i.
  - Addresses truncate to memory depth (wrap modulo depth).
- RUN_ASSERT: `run`=1 until `ctrl_idle`=0 observed -> RUN_WAIT (`run` drops same edge).
- RUN_WAIT: wait `ctrl_idle`=1 -> pulse `done`, -> IDLE.

## Timing
- Reset values: all outputs 0 (`cmd_ready`=0 during reset, 1 first cycle after release), state IDLE, counters and inst pack register 0.
- Write latency: 1 cycle; accepted beat at edge n yields write enable + addr + data valid during cycle n+1 (registered).
- `data_ready` combinational from state only; never depends on `data_valid`.
- Back-to-back beats sustained at 1 word/cycle; command accepted the cycle after last LOAD write issues (one bubble).
- RUN latency: `run` high cycle after command accept; stays high ≥1 cycle.
- `ctrl_idle` dropping during LOAD: ignored (host protocol violation); loading continues.
- Reset mid-LOAD: partial inst word discarded, no write issued.

## Configuration
- `LOAD_CHECKSUM_EN`: defined -> adds output `checksum` [`DATA_WIDTH`], modulo-2^`DATA_WIDTH` sum of all accepted data words, cleared on each non-RUN command accept, valid when back in IDLE. Undefined -> port and adder absent; behaviour otherwise identical.

## Structure
- Shared package: `LoadTarget` enum, `INST_BEATS` constant, existing `NU_COUNT`, `*_MEM_DEPTH`, `INST_MEM_SIZE`.
- One sub-module: `inst_word_packer` (beat shift/count register, emits full `INST_MEM_SIZE` word + strobe).

## Test plan
- W load, addr=4, length=2·`NU_COUNT`+1 -> NU0..N-1 at 4, NU0..N-1 at 5, NU0 at 6; one-hot enables, 1-cycle latency.
- INST load with `INST_BEATS`=3, length=7 -> two writes at addr, addr+1; 7th beat discarded.
- XY load addr=`XY_MEM_DEPTH`-1, length=2 -> writes at depth-1 then 0.
- Load issued with `ctrl_idle`=0 -> `data_ready`=0, no writes until `ctrl_idle` rises.
- RUN: `run` high until `ctrl_idle` falls; `ctrl_idle` rises 10 cycles later -> `done` pulse one cycle, `busy` 0 next.
- Reset asserted mid-INST-beat, `LOAD_CHECKSUM_EN` defined -> no write, all outputs 0, `checksum`=0.
